rx_frame_fifo: RTL

- Downstream consumer of the UART receive unit.
- Detects each completed frame on the receiver's done flag and captures the data word plus its 3-bit error vector into a FIFO.
- Presents entries to the host side on a first-word-fall-through valid/ready interface.
- Tracks fill level and reports overruns: a sticky flag plus a saturating drop counter.

---
 rtl/rx_frame_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/rx_frame_fifo.sv
// Receive-frame FIFO: captures {error, data} on each synchronized rx_done rising edge
// and serves entries first-word-fall-through, with overrun flag and saturating drop count.
module rx_frame_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_done,
    input  logic [DATA_BITS-1:0]  rx_data,
    input  logic [2:0]            rx_error,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic [2:0]            rd_error,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  overrun,
    output logic [7:0]            drop_count,
    input  logic                  ovr_clear
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int W     = DATA_BITS + 3;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   done_s, done_d, capture;
    logic                   pop, push_ok, drop;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [W-1:0]           mem [DEPTH];
    logic [W-1:0]           head;

    // Flops preset to 1 so a done level already high at reset release is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            done_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_done};
            done_d <= done_s;
        end
    end

    assign done_s  = sync_q[SYNC_STAGES-1];
    assign capture = done_s & ~done_d;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    assign push_ok  = capture & (~full | pop);
    assign drop     = capture & full & ~pop;

    // Storage is intentionally not reset; rd_data/rd_error are don't-care while empty.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= {rx_error, rx_data};
    end

    assign head     = mem[rd_ptr];
    assign rd_data  = head[DATA_BITS-1:0];
    assign rd_error = head[W-1:DATA_BITS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as ovr_clear wins and restarts the count at one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (ovr_clear)
                drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (ovr_clear) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule
